// File: rtl/fft_frame_streamer.sv
// ---------------------------------------------------------------------------
// fft_frame_streamer
//
// Reads one frame of filtered samples out of the sample buffer BRAM and
// delivers it to the FFT core. A single config beat goes out on the
// s_axis_config channel first, then the frame is streamed as an AXI-Stream
// master on s_axis_data, with tlast on the final beat.
//
// BRAM reads have one cycle of latency, so read data lands in a 2-entry skid
// FIFO. That FIFO keeps one beat per cycle going at full rate and absorbs
// any data still in flight when the FFT applies backpressure.
//
// Ports
//   clock, reset          system clock; asynchronous active-high reset
//   start                 one-cycle pulse: the buffer holds a complete frame
//   buf_en, buf_addr      BRAM read port (enable, address)
//   buf_dout              BRAM read data, valid one cycle after buf_en
//   cfg_tdata/tvalid      s_axis_config master side
//   cfg_tready            s_axis_config slave ready
//   dat_tdata/tvalid/tlast  s_axis_data master side, {16'h0000, sample}
//   dat_tready            s_axis_data slave ready
//   busy                  high from an accepted start until frame_done
//   frame_done            one-cycle pulse after the last data handshake
//   overrun               sticky: start seen while busy (cleared by reset)
// ---------------------------------------------------------------------------
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for start
// CONFIG | cfg_tvalid held with CFG_WORD until the config handshake
// STREAM | issuing BRAM reads and streaming beats until the tlast handshake
// DONE   | one-cycle frame_done pulse, then back to IDLE
//
module fft_frame_streamer #(
    parameter int          FRAME_LEN = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] CFG_WORD  = 16'h0001
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              buf_en,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [15:0]       buf_dout,
    output logic [15:0]       cfg_tdata,
    output logic              cfg_tvalid,
    input  logic              cfg_tready,
    output logic [31:0]       dat_tdata,
    output logic              dat_tvalid,
    input  logic              dat_tready,
    output logic              dat_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    // One extra bit so a count can hold FRAME_LEN itself without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_LEN - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONFIG = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q,        state_d;
    logic [CNT_W-1:0] rd_cnt_q,       rd_cnt_d;
    logic [CNT_W-1:0] beat_cnt_q,     beat_cnt_d;
    logic             inflight_q,     inflight_d;
    logic [15:0]      fifo_mem_q [0:1];
    logic [15:0]      fifo_mem_d [0:1];
    logic             fifo_rd_ptr_q,  fifo_rd_ptr_d;
    logic             fifo_wr_ptr_q,  fifo_wr_ptr_d;
    logic [1:0]       fifo_cnt_q,     fifo_cnt_d;
    logic             overrun_q,      overrun_d;

    logic        start_accept;
    logic        cfg_hs;
    logic        pop;
    logic        push;
    logic        last_hs;
    logic        rd_window;
    logic [2:0]  level;
    logic [15:0] fifo_head;

    always_comb begin
        start_accept = start && (state_q == S_IDLE);

        cfg_tvalid = (state_q == S_CONFIG);
        cfg_tdata  = cfg_tvalid ? CFG_WORD : 16'h0000;
        cfg_hs     = cfg_tvalid && cfg_tready;

        fifo_head  = fifo_mem_q[fifo_rd_ptr_q];
        dat_tvalid = (state_q == S_STREAM) && (fifo_cnt_q != 2'd0);
        dat_tdata  = dat_tvalid ? {16'h0000, fifo_head} : 32'h0000_0000;
        dat_tlast  = dat_tvalid && (beat_cnt_q == LAST_C);
        pop        = dat_tvalid && dat_tready;
        last_hs    = pop && dat_tlast;

        // Data returning from last cycle's read always gets a FIFO slot:
        // reads are only issued while FIFO occupancy plus data in flight,
        // net of this cycle's pop, leaves room for one more entry.
        push  = inflight_q;
        level = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);

        // The first read goes out in the config handshake cycle, so the
        // first beat is valid two cycles after that handshake.
        rd_window = cfg_hs || (state_q == S_STREAM);
        buf_en    = rd_window && (rd_cnt_q < LEN_C) && (level < 3'd2);
        buf_addr  = buf_en ? rd_cnt_q[ADDR_W-1:0] : '0;

        busy       = (state_q == S_CONFIG) || (state_q == S_STREAM);
        frame_done = (state_q == S_DONE);
        overrun    = overrun_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_accept) state_d = S_CONFIG;
            S_CONFIG: if (cfg_hs)       state_d = S_STREAM;
            S_STREAM: if (last_hs)      state_d = S_DONE;
            S_DONE:                     state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if (start_accept) begin
            rd_cnt_d   = '0;
            beat_cnt_d = '0;
        end else begin
            if (buf_en) rd_cnt_d   = rd_cnt_q + CNT_W'(1);
            if (pop)    beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        inflight_d = buf_en;
        overrun_d  = overrun_q || (start && (state_q != S_IDLE));
    end

    always_comb begin
        fifo_mem_d    = fifo_mem_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        if (push) begin
            fifo_mem_d[fifo_wr_ptr_q] = buf_dout;
            fifo_wr_ptr_d             = ~fifo_wr_ptr_q;
        end
        if (pop) fifo_rd_ptr_d = ~fifo_rd_ptr_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rd_cnt_q      <= '0;
            beat_cnt_q    <= '0;
            inflight_q    <= 1'b0;
            fifo_mem_q[0] <= 16'h0000;
            fifo_mem_q[1] <= 16'h0000;
            fifo_rd_ptr_q <= 1'b0;
            fifo_wr_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_cnt_q      <= rd_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            inflight_q    <= inflight_d;
            fifo_mem_q    <= fifo_mem_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            overrun_q     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_streamer
//
// Directed bench for fft_frame_streamer with a behavioural 1-cycle BRAM.
// Inputs change 1 time unit after the rising edge; outputs are observed
// 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_fft_frame_streamer;

    localparam int N = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        buf_en;
    logic [9:0]  buf_addr;
    logic [15:0] buf_dout;
    logic [15:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [31:0] dat_tdata;
    logic        dat_tvalid;
    logic        dat_tready;
    logic        dat_tlast;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    logic [15:0] mem [0:N-1];

    int n_vec = 0;
    int n_err = 0;

    fft_frame_streamer #(.FRAME_LEN(N), .ADDR_W(10), .CFG_WORD(16'h0001)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .buf_en     (buf_en),
        .buf_addr   (buf_addr),
        .buf_dout   (buf_dout),
        .cfg_tdata  (cfg_tdata),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tready (cfg_tready),
        .dat_tdata  (dat_tdata),
        .dat_tvalid (dat_tvalid),
        .dat_tready (dat_tready),
        .dat_tlast  (dat_tlast),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (buf_en) buf_dout <= mem[buf_addr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [64:0] outs;
        reset = 1'b1; start = 1'b0; cfg_tready = 1'b0; dat_tready = 1'b0;
        buf_dout = 16'h0000;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        #1;
        n_vec++;
        if (cfg_tvalid !== 1'b1 || cfg_tdata !== 16'h0001 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_config: tvalid=%b tdata=%h busy=%b want 1 0001 1", cfg_tvalid, cfg_tdata, busy);
        end
        n_vec++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_overrun: got %b want 1", overrun);
        end
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        outs = {buf_en, buf_addr, cfg_tdata, cfg_tvalid, dat_tdata, dat_tvalid, dat_tlast, busy, frame_done, overrun};
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        n_vec++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy_overrun: busy=%b overrun=%b want 0 0", busy, overrun);
        end
        tick(); tick();
        reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_full_rate();
        int beats = 0, cfg_seen = 0, cfg_cyc = -1, first_cyc = -1, last_cyc = -1, done_cyc = -1;
        logic [31:0] exp;
        for (int i = 0; i < N; i++) mem[i] = 16'(i * 3);
        cfg_tready = 1'b1; dat_tready = 1'b1;
        for (int c = 0; c < 2000 && done_cyc < 0; c++) begin
            tick();
            start = (c == 0);
            #1;
            if (cfg_tvalid && cfg_tready) begin
                cfg_seen++; cfg_cyc = c;
                n_vec++;
                if (cfg_tdata !== 16'h0001 || beats != 0) begin
                    n_err++;
                    $display("FAIL full_cfg_beat: tdata=%h beats_before=%0d want 0001 0", cfg_tdata, beats);
                end
            end
            if (first_cyc >= 0 && beats < N) begin
                n_vec++;
                if (dat_tvalid !== 1'b1) begin
                    n_err++;
                    $display("FAIL full_bubble: cycle %0d tvalid=%b want 1", c, dat_tvalid);
                end
            end
            if (dat_tvalid && dat_tready) begin
                if (first_cyc < 0) first_cyc = c;
                exp = {16'h0000, 16'(beats * 3)};
                n_vec++;
                if (dat_tdata !== exp) begin
                    n_err++;
                    $display("FAIL full_tdata: beat %0d got %h want %h", beats, dat_tdata, exp);
                end
                n_vec++;
                if (dat_tlast !== (beats == N - 1)) begin
                    n_err++;
                    $display("FAIL full_tlast: beat %0d got %b want %b", beats, dat_tlast, beats == N - 1);
                end
                last_cyc = c;
                beats++;
            end
            if (frame_done) done_cyc = c;
        end
        start = 1'b0;
        n_vec++;
        if (cfg_seen != 1 || cfg_cyc != 1) begin
            n_err++;
            $display("FAIL full_cfg_count: seen %0d at cycle %0d want 1 at 1", cfg_seen, cfg_cyc);
        end
        n_vec++;
        if (first_cyc != cfg_cyc + 2) begin
            n_err++;
            $display("FAIL full_first_latency: first beat cycle %0d want %0d", first_cyc, cfg_cyc + 2);
        end
        n_vec++;
        if (beats != N) begin
            n_err++;
            $display("FAIL full_beat_count: got %0d want %0d", beats, N);
        end
        n_vec++;
        if (done_cyc != last_cyc + 1 || done_cyc < 1026 || done_cyc > 1028) begin
            n_err++;
            $display("FAIL full_done_timing: done %0d last %0d want last+1 in 1026..1028", done_cyc, last_cyc);
        end
        tick(); #1;
        n_vec++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL full_after_done: busy=%b done=%b want 0 0", busy, frame_done);
        end
        repeat (3) tick();
    endtask

    task automatic test_config_stall();
        int beats = 0, cfg_cyc = -1, first_cyc = -1, last_idx = -1, done_cyc = -1;
        dat_tready = 1'b1;
        for (int c = 0; c < 3000 && done_cyc < 0; c++) begin
            tick();
            start = (c == 0);
            cfg_tready = (c >= 6);
            #1;
            if (c >= 1 && c <= 5) begin
                n_vec++;
                if (cfg_tvalid !== 1'b1 || cfg_tdata !== 16'h0001) begin
                    n_err++;
                    $display("FAIL stall_cfg_hold: cycle %0d tvalid=%b tdata=%h want 1 0001", c, cfg_tvalid, cfg_tdata);
                end
                n_vec++;
                if (dat_tvalid !== 1'b0 || buf_en !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_no_data: cycle %0d dat_tvalid=%b buf_en=%b want 0 0", c, dat_tvalid, buf_en);
                end
            end
            if (cfg_tvalid && cfg_tready) cfg_cyc = c;
            if (dat_tvalid && dat_tready) begin
                if (first_cyc < 0) first_cyc = c;
                if (dat_tlast) last_idx = beats;
                beats++;
            end
            if (frame_done) done_cyc = c;
        end
        start = 1'b0; cfg_tready = 1'b1;
        n_vec++;
        if (cfg_cyc != 6 || first_cyc != 8) begin
            n_err++;
            $display("FAIL stall_timing: cfg %0d first %0d want 6 8", cfg_cyc, first_cyc);
        end
        n_vec++;
        if (beats != N || last_idx != N - 1 || done_cyc != 1032) begin
            n_err++;
            $display("FAIL stall_frame: beats %0d tlast %0d done %0d want %0d %0d 1032", beats, last_idx, done_cyc, N, N - 1);
        end
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        int acc = 0, issued = 0, done_cyc = -1, extra = 0;
        logic prev_stall = 1'b0;
        logic prev_last = 1'b0;
        logic pop_now;
        logic [31:0] prev_data = '0;
        logic [31:0] exp;
        for (int i = 0; i < N; i++) mem[i] = 16'h8000 ^ 16'(i);
        cfg_tready = 1'b1;
        for (int c = 0; c < 8000 && done_cyc < 0; c++) begin
            tick();
            start = (c == 0);
            dat_tready = (c >= 100 && c < 140) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            pop_now = dat_tvalid && dat_tready;
            if (prev_stall) begin
                n_vec++;
                if (dat_tvalid !== 1'b1 || dat_tdata !== prev_data || dat_tlast !== prev_last) begin
                    n_err++;
                    $display("FAIL bp_stall_hold: cycle %0d got %b %h %b want 1 %h %b", c, dat_tvalid, dat_tdata, dat_tlast, prev_data, prev_last);
                end
            end
            if (buf_en) begin
                n_vec++;
                if (buf_addr !== 10'(issued) || issued >= N) begin
                    n_err++;
                    $display("FAIL bp_addr: got %0d want %0d", buf_addr, issued);
                end
                issued++;
                n_vec++;
                if (issued > acc + int'(pop_now) + 2) begin
                    n_err++;
                    $display("FAIL bp_outstanding: issued %0d accepted %0d want issued <= accepted+2", issued, acc + int'(pop_now));
                end
            end
            if (pop_now) begin
                exp = {16'h0000, 16'h8000 ^ 16'(acc)};
                n_vec++;
                if (dat_tdata !== exp || dat_tlast !== (acc == N - 1)) begin
                    n_err++;
                    $display("FAIL bp_beat: beat %0d got %h last %b want %h last %b", acc, dat_tdata, dat_tlast, exp, acc == N - 1);
                end
                acc++;
            end
            prev_stall = dat_tvalid && !dat_tready;
            prev_data  = dat_tdata;
            prev_last  = dat_tlast;
            if (frame_done) done_cyc = c;
        end
        start = 1'b0; dat_tready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(); #1;
            if (dat_tvalid || buf_en || cfg_tvalid) extra++;
        end
        n_vec++;
        if (acc != N || issued != N || done_cyc < 0 || extra != 0) begin
            n_err++;
            $display("FAIL bp_totals: accepted %0d issued %0d done %0d extra %0d want %0d %0d >=0 0", acc, issued, done_cyc, extra, N, N);
        end
    endtask

    task automatic test_overrun();
        int acc = 0, cfg_cnt = 0, fire_cyc = -1, done_cyc = -1, extra = 0;
        logic [31:0] exp;
        for (int i = 0; i < N; i++) mem[i] = 16'(i * 5 + 1);
        cfg_tready = 1'b1; dat_tready = 1'b1;
        for (int c = 0; c < 3000 && done_cyc < 0; c++) begin
            tick();
            start = (c == 0) || (fire_cyc < 0 && acc == 400);
            if (c != 0 && start) fire_cyc = c;
            #1;
            if (c == 0) begin
                n_vec++;
                if (overrun !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovr_initial: got %b want 0", overrun);
                end
            end
            if (fire_cyc >= 0 && c == fire_cyc + 1) begin
                n_vec++;
                if (overrun !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovr_set: got %b want 1", overrun);
                end
            end
            if (cfg_tvalid && cfg_tready) cfg_cnt++;
            if (dat_tvalid && dat_tready) begin
                exp = {16'h0000, 16'(acc * 5 + 1)};
                n_vec++;
                if (dat_tdata !== exp || dat_tlast !== (acc == N - 1)) begin
                    n_err++;
                    $display("FAIL ovr_beat: beat %0d got %h last %b want %h last %b", acc, dat_tdata, dat_tlast, exp, acc == N - 1);
                end
                acc++;
            end
            if (frame_done) done_cyc = c;
        end
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick(); #1;
            if (cfg_tvalid || dat_tvalid || busy || buf_en) extra++;
        end
        n_vec++;
        if (acc != N || cfg_cnt != 1 || fire_cyc != 403 || extra != 0) begin
            n_err++;
            $display("FAIL ovr_frame: beats %0d cfg %0d fire %0d extra %0d want %0d 1 403 0", acc, cfg_cnt, fire_cyc, extra, N);
        end
        n_vec++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_sticky: got %b want 1", overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        int acc = 0, cfg_cnt = 0, done_cyc = -1, last_idx = -1;
        logic [31:0] exp;
        logic [64:0] outs;
        cfg_tready = 1'b1; dat_tready = 1'b1;
        for (int c = 0; c < 2000 && acc < 300; c++) begin
            tick();
            start = (c == 0);
            #1;
            if (dat_tvalid && dat_tready) acc++;
        end
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        outs = {buf_en, buf_addr, cfg_tdata, cfg_tvalid, dat_tdata, dat_tvalid, dat_tlast, busy, frame_done, overrun};
        n_vec++;
        if (acc != 300 || outs !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: beats %0d outs %h want 300 0", acc, outs);
        end
        tick(); tick();
        reset = 1'b0;
        acc = 0;
        for (int c = 0; c < 2000 && done_cyc < 0; c++) begin
            tick();
            start = (c == 0);
            #1;
            if (cfg_tvalid && cfg_tready) begin
                cfg_cnt++;
                n_vec++;
                if (cfg_tdata !== 16'h0001 || acc != 0) begin
                    n_err++;
                    $display("FAIL midrst_cfg: tdata %h beats_before %0d want 0001 0", cfg_tdata, acc);
                end
            end
            if (dat_tvalid && dat_tready) begin
                exp = {16'h0000, 16'(acc * 5 + 1)};
                n_vec++;
                if (dat_tdata !== exp) begin
                    n_err++;
                    $display("FAIL midrst_tdata: beat %0d got %h want %h", acc, dat_tdata, exp);
                end
                if (dat_tlast) last_idx = acc;
                acc++;
            end
            if (frame_done) done_cyc = c;
        end
        start = 1'b0;
        n_vec++;
        if (cfg_cnt != 1 || acc != N || last_idx != N - 1 || done_cyc < 0) begin
            n_err++;
            $display("FAIL midrst_frame: cfg %0d beats %0d tlast %0d done %0d want 1 %0d %0d >=0", cfg_cnt, acc, last_idx, done_cyc, N, N - 1);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_config_stall();
        test_backpressure();
        test_overrun();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
